// File: rtl/mix_cols_iter.sv
// mix_cols_iter: iterative AES MixColumns engine with a valid/ready handshake.
// A 128-bit state is latched on acceptance and transformed COLS_PER_CYC
// columns per cycle. Forward, inverse or bypass mode is chosen per block.
// Bypass rewrites the columns unchanged, so every mode has the same latency.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   din/mode valid            in_ready   engine can accept a block
//   mode       00 fwd, 01 inv, 1x bypass din        input state (column-major)
//   out_valid  dout valid                out_ready  downstream accepts dout
//   dout       result state, held while out_valid=1
module mix_cols_iter #(
    parameter int COLS_PER_CYC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   mode,
    input  logic [127:0] din,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout
);
    localparam int NSTEP = 4 / COLS_PER_CYC;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    generate
        if (!(COLS_PER_CYC == 1 || COLS_PER_CYC == 2 || COLS_PER_CYC == 4)) begin : g_bad_cfg
            $error("mix_cols_iter: COLS_PER_CYC must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [127:0]    data_q, data_d;
    logic [1:0]      mode_q, mode_d;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the forward or inverse matrix. Inverse coefficients
    // are sums of the 2x/4x/8x xtime chain: 9=8+1, b=8+2+1, d=8+4+1, e=8+4+2.
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0] a [4];
        logic [7:0] x2[4];
        logic [7:0] x4[4];
        logic [7:0] x8[4];
        logic [31:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            a[r]  = c[31-8*r -: 8];
            x2[r] = xt(a[r]);
            x4[r] = xt(x2[r]);
            x8[r] = xt(x4[r]);
        end
        for (int r = 0; r < 4; r++) begin
            if (inv)
                o[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                               ^ (x8[(r+1)&3] ^ x2[(r+1)&3] ^ a[(r+1)&3])
                               ^ (x8[(r+2)&3] ^ x4[(r+2)&3] ^ a[(r+2)&3])
                               ^ (x8[(r+3)&3] ^ a[(r+3)&3]);
            else
                o[31-8*r -: 8] = x2[r] ^ x2[(r+1)&3] ^ a[(r+1)&3]
                               ^ a[(r+2)&3] ^ a[(r+3)&3];
        end
        return o;
    endfunction

    always_comb begin
        int          idx;
        logic [31:0] col;
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        mode_d   = mode_q;
        in_ready = 1'b0;
        idx      = 0;
        col      = '0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = din;
                    mode_d  = mode;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int j = 0; j < COLS_PER_CYC; j++) begin
                    idx = int'(cnt_q) * COLS_PER_CYC + j;
                    col = data_q[127-32*idx -: 32];
                    if (!mode_q[1])
                        col = mix_col(col, mode_q[0]);
                    data_d[127-32*idx -: 32] = col;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NSTEP - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // The DONE cycle doubles as the acceptance slot for the next block.
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        data_d  = din;
                        mode_d  = mode;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign dout      = data_q;

endmodule

// File: tb/tb_mix_cols_iter.sv
// Bench for mix_cols_iter: three instances (1, 2 and 4 columns per cycle)
// share clock, reset, din and mode, each with its own handshake lines.
// Expected results come from a generic GF(2^8) matrix-multiply model.
module tb_mix_cols_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [1:0]   mode;
    logic [127:0] din;
    logic         iv  [3];
    logic         ordy[3];
    logic         irdy[3];
    logic         ov  [3];
    logic [127:0] dq  [3];

    int n_cmp = 0;
    int n_bad = 0;

    mix_cols_iter #(.COLS_PER_CYC(1)) u_c1 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
        .mode(mode), .din(din), .out_valid(ov[0]), .out_ready(ordy[0]), .dout(dq[0]));
    mix_cols_iter #(.COLS_PER_CYC(2)) u_c2 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
        .mode(mode), .din(din), .out_valid(ov[1]), .out_ready(ordy[1]), .dout(dq[1]));
    mix_cols_iter #(.COLS_PER_CYC(4)) u_c4 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
        .mode(mode), .din(din), .out_valid(ov[2]), .out_ready(ordy[2]), .dout(dq[2]));

    function automatic int nstep(input int k);
        return 4 >> k;
    endfunction

    // Shift-and-add GF(2^8) multiply, polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // out_r = sum_k cf[(k-r) mod 4] * a_k over each column.
    function automatic logic [127:0] model(input logic [127:0] d, input logic [1:0] m);
        logic [7:0]   cf[4];
        logic [7:0]   a [4];
        logic [7:0]   o;
        logic [127:0] res;
        if (m[1]) return d;
        if (m[0]) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
        else      begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = d[127-32*c-8*r -: 8];
            for (int r = 0; r < 4; r++) begin
                o = 8'h00;
                for (int k = 0; k < 4; k++) o = o ^ gmul(a[k], cf[(k-r)&3]);
                res[127-32*c-8*r -: 8] = o;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives one block into instance k (called at a negedge with ordy[k] set),
    // returns cycles from the accepting edge to out_valid, and the result.
    task automatic send(input int k, input logic [127:0] d, input logic [1:0] m,
                        output int lat, output logic [127:0] res);
        int w;
        w = 0;
        while (!irdy[k] && w < 50) begin @(negedge clk); w++; end
        iv[k] = 1'b1; din = d; mode = m;
        @(negedge clk);
        iv[k] = 1'b0;
        lat = 0;
        while (!ov[k] && lat < 50) begin @(negedge clk); lat++; end
        res = dq[k];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (ov[k] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, ov[k]); end
            n_cmp++; if (dq[k] !== 128'h0) begin n_bad++; $display("FAIL reset_dout[%0d]: got %h want 0", k, dq[k]); end
            n_cmp++; if (irdy[k] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, irdy[k]); end
        end
    endtask

    task automatic test_forward();
        int lat; logic [127:0] res;
        send(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 2'b00, lat, res);
        n_cmp++; if (res !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6) begin n_bad++;
            $display("FAIL fwd_vector: got %h want 8e4da1bc9fdc589d01010101c6c6c6c6", res); end
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL fwd_latency: got %0d want 4", lat); end
        for (int i = 0; i < 3; i++) begin
            logic [127:0] d;
            d = rnd128();
            send(0, d, 2'b00, lat, res);
            n_cmp++; if (res !== model(d, 2'b00)) begin n_bad++;
                $display("FAIL fwd_random: got %h want %h", res, model(d, 2'b00)); end
        end
    endtask

    task automatic test_inverse();
        int lat; logic [127:0] res;
        for (int k = 0; k < 3; k++) begin
            send(k, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 2'b01, lat, res);
            n_cmp++; if (res !== 128'hdb135345_f20a225c_d4d4d4d5_2d26314c) begin n_bad++;
                $display("FAIL inv_vector[%0d]: got %h want db135345f20a225cd4d4d4d52d26314c", k, res); end
            n_cmp++; if (lat !== nstep(k)) begin n_bad++;
                $display("FAIL inv_latency[%0d]: got %0d want %0d", k, lat, nstep(k)); end
        end
    endtask

    task automatic test_bypass();
        int lat; logic [127:0] res;
        for (int k = 0; k < 3; k++) begin
            send(k, 128'h00112233_44556677_8899aabb_ccddeeff, (k == 1) ? 2'b11 : 2'b10, lat, res);
            n_cmp++; if (res !== 128'h00112233_44556677_8899aabb_ccddeeff) begin n_bad++;
                $display("FAIL bypass_data[%0d]: got %h want 00112233445566778899aabbccddeeff", k, res); end
            n_cmp++; if (lat !== nstep(k)) begin n_bad++;
                $display("FAIL bypass_latency[%0d]: got %0d want %0d", k, lat, nstep(k)); end
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [127:0] res, d1, d2, e1;
        logic [1:0] m2;
        d1 = rnd128(); e1 = model(d1, 2'b01);
        ordy[0] = 1'b0;
        send(0, d1, 2'b01, lat, res);
        n_cmp++; if (res !== e1) begin n_bad++; $display("FAIL bp_first: got %h want %h", res, e1); end
        for (int i = 0; i < 10; i++) begin
            mode = 2'($urandom);
            @(negedge clk);
            n_cmp++; if (ov[0] !== 1'b1 || dq[0] !== e1 || irdy[0] !== 1'b0) begin n_bad++;
                $display("FAIL bp_hold cyc%0d: got ov=%b rdy=%b dout=%h want ov=1 rdy=0 dout=%h",
                         i, ov[0], irdy[0], dq[0], e1); end
        end
        d2 = rnd128(); m2 = 2'($urandom_range(0, 1));
        ordy[0] = 1'b1; iv[0] = 1'b1; din = d2; mode = m2;
        @(negedge clk);
        iv[0] = 1'b0;
        n_cmp++; if (ov[0] !== 1'b0 || irdy[0] !== 1'b0) begin n_bad++;
            $display("FAIL bp_accept: got ov=%b rdy=%b want ov=0 rdy=0", ov[0], irdy[0]); end
        lat = 0;
        while (!ov[0] && lat < 50) begin @(negedge clk); lat++; end
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL bp_latency: got %0d want 4", lat); end
        n_cmp++; if (dq[0] !== model(d2, m2)) begin n_bad++;
            $display("FAIL bp_second: got %h want %h", dq[0], model(d2, m2)); end
        @(negedge clk);
    endtask

    // Results arrive every NSTEP+1 cycles: the DONE cycle of one block is the
    // acceptance cycle of the next. mode is scrambled whenever the engine is busy.
    task automatic test_back_to_back(input int k);
        logic [127:0] exp_q[$];
        logic [127:0] blk[8];
        logic [127:0] e;
        int cyc, last, got, idx;
        logic acc;
        cyc = 0; last = -1; got = 0; idx = 0;
        for (int i = 0; i < 8; i++) blk[i] = rnd128();
        din = blk[0]; mode = 2'($urandom); iv[k] = 1'b1;
        while (got < 8 && cyc < 400) begin
            acc = iv[k] && irdy[k];
            if (acc) exp_q.push_back(model(din, mode));
            else if (iv[k]) mode = 2'($urandom);
            @(negedge clk); cyc++;
            if (acc) begin
                idx++;
                if (idx < 8) begin din = blk[idx]; mode = 2'($urandom); end
                else iv[k] = 1'b0;
            end
            if (ov[k]) begin
                got++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                n_cmp++; if (dq[k] !== e) begin n_bad++;
                    $display("FAIL stream[%0d] blk%0d: got %h want %h", k, got, dq[k], e); end
                if (last >= 0) begin
                    n_cmp++; if (cyc - last !== nstep(k) + 1) begin n_bad++;
                        $display("FAIL stream_gap[%0d]: got %0d want %0d", k, cyc - last, nstep(k) + 1); end
                end
                last = cyc;
            end
        end
        iv[k] = 1'b0;
        n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL stream_count[%0d]: got %0d want 8", k, got); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        int lat; logic [127:0] res, d;
        iv[0] = 1'b1; din = rnd128(); mode = 2'b00;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (ov[0] !== 1'b0 || dq[0] !== 128'h0 || irdy[0] !== 1'b1) begin n_bad++;
            $display("FAIL midreset: got ov=%b rdy=%b dout=%h want ov=0 rdy=1 dout=0", ov[0], irdy[0], dq[0]); end
        d = rnd128();
        send(0, d, 2'b01, lat, res);
        n_cmp++; if (res !== model(d, 2'b01) || lat !== 4) begin n_bad++;
            $display("FAIL after_reset: got %h lat %0d want %h lat 4", res, lat, model(d, 2'b01)); end
    endtask

    initial begin
        rst = 1'b1; mode = 2'b00; din = '0;
        for (int k = 0; k < 3; k++) begin iv[k] = 1'b0; ordy[k] = 1'b1; end
        test_reset();
        test_forward();
        test_inverse();
        test_bypass();
        test_backpressure();
        for (int k = 0; k < 3; k++) test_back_to_back(k);
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
